// File: rtl/cbs_pkg.sv
// Shared definitions for the credit-based shaper/policer family: credit widths,
// policer state encoding and byte-count helpers.
package cbs_pkg;

    localparam int CREDIT_W     = 32;
    localparam int CREDIT_SUM_W = 40;
    localparam int MAX_KEEP_W   = 64;
    localparam int BYTES_W      = 8;

    typedef enum logic [1:0] {
        ST_SOF  = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } pol_state_t;

    // Caller zero-extends tkeep to MAX_KEEP_W so one function serves every width.
    function automatic logic [BYTES_W-1:0] keep_popcount(input logic [MAX_KEEP_W-1:0] keep);
        logic [BYTES_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            cnt = cnt + BYTES_W'(keep[i]);
        end
        return cnt;
    endfunction

    function automatic logic signed [CREDIT_SUM_W-1:0] credit_sext(input logic signed [CREDIT_W-1:0] v);
        return {{(CREDIT_SUM_W-CREDIT_W){v[CREDIT_W-1]}}, v};
    endfunction

endpackage

// File: rtl/cbs_ingress_policer_if.sv
// AXI4-Stream bundle for the policer ports; master drives data, slave drives tready.
// Width is set per instance, so ingress and egress share one definition.
interface cbs_ingress_policer_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = DATA_W / 8
) ();

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/cbs_credit_counter.sv
// Credit accumulator: adds idle slope every cycle and send slope per consumed byte, saturated.
// One-cycle update latency; no handshake of its own, it simply follows i_consume.
module cbs_credit_counter
    import cbs_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [CREDIT_W-1:0] i_idle_slope,
    input  logic signed [CREDIT_W-1:0] i_send_slope,
    input  logic signed [CREDIT_W-1:0] i_max_credit,
    input  logic signed [CREDIT_W-1:0] i_min_credit,
    input  logic                       i_consume,
    input  logic [BYTES_W-1:0]         i_bytes,
    output logic signed [CREDIT_W-1:0] o_credit
);

    logic signed [CREDIT_W-1:0]     r_credit;
    logic signed [CREDIT_SUM_W-1:0] w_credit_ext;
    logic signed [CREDIT_SUM_W-1:0] w_idle_ext;
    logic signed [CREDIT_SUM_W-1:0] w_send_ext;
    logic signed [CREDIT_SUM_W-1:0] w_max_ext;
    logic signed [CREDIT_SUM_W-1:0] w_min_ext;
    logic signed [CREDIT_SUM_W-1:0] w_bytes_ext;
    logic signed [CREDIT_SUM_W-1:0] w_debit;
    logic signed [CREDIT_SUM_W-1:0] w_sum;
    logic signed [CREDIT_SUM_W-1:0] w_floor;
    logic signed [CREDIT_SUM_W-1:0] w_sat;

    assign w_credit_ext = credit_sext(r_credit);
    assign w_idle_ext   = credit_sext(i_idle_slope);
    assign w_send_ext   = credit_sext(i_send_slope);
    assign w_max_ext    = credit_sext(i_max_credit);
    assign w_min_ext    = credit_sext(i_min_credit);
    assign w_bytes_ext  = $signed({{(CREDIT_SUM_W-BYTES_W){1'b0}}, i_bytes});

    // 40 bits hold the full credit + idle + (send * 64 bytes) without wrapping.
    assign w_debit = i_consume ? (w_send_ext * w_bytes_ext) : '0;
    assign w_sum   = w_credit_ext + w_idle_ext + w_debit;

    // Upper bound applied last so a misconfigured min > max resolves to max.
    assign w_floor = (w_sum < w_min_ext) ? w_min_ext : w_sum;
    assign w_sat   = (w_floor > w_max_ext) ? w_max_ext : w_floor;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= '0;
        end else begin
            r_credit <= w_sat[CREDIT_W-1:0];
        end
    end

    assign o_credit = r_credit;

endmodule

// File: rtl/cbs_ingress_policer.sv
// Per-class ingress policer: forwards or drops whole frames based on credit at the first beat.
// Zero-latency pass-through; forwarded frames follow m_axis.tready, dropped frames are sunk at full rate.
module cbs_ingress_policer
    import cbs_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [CREDIT_W-1:0] idle_slope,
    input  logic signed [CREDIT_W-1:0] send_slope,
    input  logic signed [CREDIT_W-1:0] max_credit,
    input  logic signed [CREDIT_W-1:0] min_credit,
    output logic signed [CREDIT_W-1:0] credit,
    output logic [31:0]                pass_frames,
    output logic [31:0]                drop_frames,
    cbs_ingress_policer_if.slave       s_axis,
    cbs_ingress_policer_if.master      m_axis
);

    if (C_AXIS_TKEEP_WIDTH * 8 != C_AXIS_TDATA_WIDTH) begin : g_bad_width
        $error("cbs_ingress_policer: tkeep width must be tdata width / 8");
    end
    if (C_AXIS_TKEEP_WIDTH > MAX_KEEP_W) begin : g_bad_keep
        $error("cbs_ingress_policer: tkeep wider than popcount helper supports");
    end

    pol_state_t              r_state;
    pol_state_t              w_state_nxt;
    logic                    w_keep;
    logic                    w_m_vld;
    logic                    w_s_rdy;
    logic                    w_pass_inc;
    logic                    w_drop_inc;
    logic                    w_m_hs;
    logic [MAX_KEEP_W-1:0]   w_keep_ext;
    logic [BYTES_W-1:0]      w_beat_bytes;
    logic [31:0]             r_pass_frames;
    logic [31:0]             r_drop_frames;

    // A frame is admitted whenever credit is non-negative (zero passes).
    assign w_keep = ~credit[CREDIT_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SOF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_m_vld     = 1'b0;
        w_s_rdy     = 1'b0;
        w_pass_inc  = 1'b0;
        w_drop_inc  = 1'b0;
        case (r_state)
            ST_SOF: begin
                if (s_axis.tvalid) begin
                    if (w_keep) begin
                        w_m_vld = 1'b1;
                        w_s_rdy = m_axis.tready;
                        // Entering PASS even when stalled latches the decision, so
                        // m_axis.tvalid is never withdrawn if credit later dips.
                        if (m_axis.tready && s_axis.tlast) begin
                            w_pass_inc = 1'b1;
                        end else begin
                            w_state_nxt = ST_PASS;
                        end
                    end else begin
                        w_s_rdy = 1'b1;
                        if (s_axis.tlast) begin
                            w_drop_inc = 1'b1;
                        end else begin
                            w_state_nxt = ST_DROP;
                        end
                    end
                end
            end
            ST_PASS: begin
                w_m_vld = s_axis.tvalid;
                w_s_rdy = m_axis.tready;
                if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
                    w_pass_inc  = 1'b1;
                    w_state_nxt = ST_SOF;
                end
            end
            ST_DROP: begin
                w_s_rdy = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) begin
                    w_drop_inc  = 1'b1;
                    w_state_nxt = ST_SOF;
                end
            end
            default: begin
                w_state_nxt = ST_SOF;
            end
        endcase
    end

    assign m_axis.tdata  = s_axis.tdata;
    assign m_axis.tkeep  = s_axis.tkeep;
    assign m_axis.tlast  = s_axis.tlast;
    assign m_axis.tvalid = w_m_vld;
    assign s_axis.tready = w_s_rdy;

    // Only beats actually accepted downstream spend credit; dropped beats are free.
    assign w_m_hs = w_m_vld & m_axis.tready;

    always_comb begin
        w_keep_ext                         = '0;
        w_keep_ext[C_AXIS_TKEEP_WIDTH-1:0] = s_axis.tkeep;
    end

    assign w_beat_bytes = keep_popcount(w_keep_ext);

    cbs_credit_counter u_credit (
        .clk          (clk),
        .rst          (rst),
        .i_idle_slope (idle_slope),
        .i_send_slope (send_slope),
        .i_max_credit (max_credit),
        .i_min_credit (min_credit),
        .i_consume    (w_m_hs),
        .i_bytes      (w_beat_bytes),
        .o_credit     (credit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass_frames <= '0;
            r_drop_frames <= '0;
        end else begin
            if (w_pass_inc) begin
                r_pass_frames <= r_pass_frames + 32'd1;
            end
            if (w_drop_inc) begin
                r_drop_frames <= r_drop_frames + 32'd1;
            end
        end
    end

    assign pass_frames = r_pass_frames;
    assign drop_frames = r_drop_frames;

endmodule
